// File: rtl/ext_bus_target.sv
// Target end of the multiplexed 16-bit external bus: latches a 32-bit address
// from ALE0/ALE1 and turns OE_N/WE_N strobes into valid/ready halfword requests.
module ext_bus_target #(
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter logic [31:0] MASK = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        isout,
  input  logic        ale0,
  input  logic        ale1,
  input  logic        oe_n,
  input  logic        we_n,
  input  logic        bhe_n,
  output logic        valid,
  input  logic        ready,
  output logic        rw,
  output logic [31:0] addr,
  output logic [15:0] mdout,
  output logic [1:0]  wstrb,
  input  logic [15:0] mdin,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DRIVE, WR_HOLD, WR_REQ} state_t;

  state_t      state_q, state_d;
  logic [15:0] din_q, din_qq;
  logic        ale0_q, ale0_qq, ale1_q, ale1_qq;
  logic        oe_n_q, oe_n_qq, we_n_q, we_n_qq, bhe_n_q;
  logic [31:0] alat_q;
  logic [31:0] raddr_q, raddr_d;
  logic        valid_q, valid_d, rw_q, rw_d, isout_q, isout_d, err_q, err_d;
  logic [15:0] dout_q, dout_d, mdout_q, mdout_d;
  logic [1:0]  wstrb_q, wstrb_d, ws;

  logic oe_fall, we_fall, we_rise, hit, both_low;

  assign oe_fall  = oe_n_qq & ~oe_n_q;
  assign we_fall  = we_n_qq & ~we_n_q;
  assign we_rise  = ~we_n_qq & we_n_q;
  assign hit      = ((alat_q & MASK) == BASE);
  assign both_low = ~oe_n_q & ~we_n_q;
  assign ws       = {~bhe_n_q, ~raddr_q[0]};

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    valid_d = valid_q;
    rw_d    = rw_q;
    isout_d = isout_q;
    err_d   = err_q;
    dout_d  = dout_q;
    mdout_d = mdout_q;
    wstrb_d = wstrb_q;
    if (hit && both_low) err_d = 1'b1;
    if (state_q != IDLE && (oe_fall || we_fall)) err_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (oe_fall && hit && we_n_q) begin
          state_d = RD_REQ;
          valid_d = 1'b1;
          rw_d    = 1'b0;
          raddr_d = alat_q;
          wstrb_d = {~bhe_n_q, ~alat_q[0]};
        end else if (we_fall && hit && oe_n_q) begin
          state_d = WR_HOLD;
          raddr_d = alat_q;
        end
      end
      RD_REQ: begin
        if (ready) begin
          valid_d = 1'b0;
          dout_d  = mdin;
          // A read whose OE already went away is completed but never driven
          if (!oe_n_q) begin
            state_d = RD_DRIVE;
            isout_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RD_DRIVE: begin
        if (oe_n_q) begin
          isout_d = 1'b0;
          state_d = IDLE;
        end
      end
      WR_HOLD: begin
        if (we_rise) begin
          mdout_d = din_qq;
          wstrb_d = ws;
          if (ws == 2'b00) begin
            state_d = IDLE;
          end else begin
            state_d = WR_REQ;
            valid_d = 1'b1;
            rw_d    = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      din_q   <= '0;
      din_qq  <= '0;
      ale0_q  <= 1'b0;
      ale0_qq <= 1'b0;
      ale1_q  <= 1'b0;
      ale1_qq <= 1'b0;
      oe_n_q  <= 1'b1;
      oe_n_qq <= 1'b1;
      we_n_q  <= 1'b1;
      we_n_qq <= 1'b1;
      bhe_n_q <= 1'b1;
      alat_q  <= '0;
      state_q <= IDLE;
      raddr_q <= '0;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      isout_q <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      mdout_q <= '0;
      wstrb_q <= '0;
    end else begin
      din_q   <= din;
      din_qq  <= din_q;
      ale0_q  <= ale0;
      ale0_qq <= ale0_q;
      ale1_q  <= ale1;
      ale1_qq <= ale1_q;
      oe_n_q  <= oe_n;
      oe_n_qq <= oe_n_q;
      we_n_q  <= we_n;
      we_n_qq <= we_n_q;
      bhe_n_q <= bhe_n;
      // din_qq holds the sample taken in the last strobe-high cycle
      if (ale0_qq && !ale0_q) alat_q[15:0]  <= din_qq;
      if (ale1_qq && !ale1_q) alat_q[31:16] <= din_qq;
      state_q <= state_d;
      raddr_q <= raddr_d;
      valid_q <= valid_d;
      rw_q    <= rw_d;
      isout_q <= isout_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      mdout_q <= mdout_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Request address is frozen while valid so a stray ALE cannot disturb it
  assign addr  = valid_q ? raddr_q : alat_q;
  assign valid = valid_q;
  assign rw    = rw_q;
  assign mdout = mdout_q;
  assign wstrb = wstrb_q;
  assign dout  = dout_q;
  assign isout = isout_q & we_n_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ext_bus_target.sv
// Bench for ext_bus_target: directed bus sequences plus randomized read/write
// traffic scored against a transaction-level model of the bus target.
module tb_ext_bus_target;

  logic        i_clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        ale0, ale1, oe_n, we_n, bhe_n, ready;
  logic [15:0] mdin;
  logic [15:0] dout, mdout;
  logic        isout, valid, rw, err;
  logic [31:0] addr;
  logic [1:0]  wstrb;
  logic [15:0] dout2, mdout2;
  logic        isout2, valid2, rw2, err2;
  logic [31:0] addr2;
  logic [1:0]  wstrb2;

  always #5 i_clk = ~i_clk;

  ext_bus_target dut (
    .i_clk(i_clk), .reset(reset), .din(din), .dout(dout), .isout(isout),
    .ale0(ale0), .ale1(ale1), .oe_n(oe_n), .we_n(we_n), .bhe_n(bhe_n),
    .valid(valid), .ready(ready), .rw(rw), .addr(addr), .mdout(mdout),
    .wstrb(wstrb), .mdin(mdin), .err(err));

  ext_bus_target #(.BASE(32'h8000_0000), .MASK(32'hF000_0000)) dut2 (
    .i_clk(i_clk), .reset(reset), .din(din), .dout(dout2), .isout(isout2),
    .ale0(ale0), .ale1(ale1), .oe_n(oe_n), .we_n(we_n), .bhe_n(bhe_n),
    .valid(valid2), .ready(1'b1), .rw(rw2), .addr(addr2), .mdout(mdout2),
    .wstrb(wstrb2), .mdin(mdin), .err(err2));

  typedef struct packed {
    logic [31:0] a;
    logic        w;
    logic [15:0] d;
    logic [1:0]  s;
  } hs_t;

  int   n_tests = 0, n_fail = 0;
  int   vcyc = 0, iscnt = 0, v2cnt = 0, is2cnt = 0, stab_err = 0, hs_tot = 0;
  hs_t  hs_q[$];
  bit   ready_tie = 1'b1;
  int   dly = 0;
  bit   md_fix_en = 1'b0;
  logic [15:0] md_fix = '0;

  function automatic logic [15:0] memf(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h3C5A;
  endfunction

  assign mdin = md_fix_en ? md_fix : memf(addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Memory responder: ready after dly wait cycles, or tied high
  initial begin
    int cnt;
    cnt = 0;
    ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      if (ready_tie) ready = 1'b1;
      else if (!valid) begin ready = 1'b0; cnt = 0; end
      else if (!ready) begin
        if (cnt >= dly) ready = 1'b1;
        else cnt++;
      end
    end
  end

  // Monitor: counts strobe cycles, records handshakes, tracks request stability
  initial begin
    bit  pv;
    hs_t pk, cur;
    pv = 1'b0;
    pk = '0;
    forever begin
      @(negedge i_clk);
      if (!reset) begin
        cur = '{addr, rw, mdout, wstrb};
        if (valid)  vcyc++;
        if (isout)  iscnt++;
        if (valid2) v2cnt++;
        if (isout2) is2cnt++;
        if (valid && pv && cur != pk) stab_err++;
        pv = valid && !ready;
        pk = cur;
        if (valid && ready) begin hs_q.push_back(cur); hs_tot++; end
      end else pv = 1'b0;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    hs_q.delete();
  endtask

  task automatic set_addr(input logic [31:0] a);
    ale0 = 1'b1; din = a[15:0];  tick();
    ale0 = 1'b0; din = 16'($urandom); tick();
    ale1 = 1'b1; din = a[31:16]; tick();
    ale1 = 1'b0; din = 16'($urandom); tick(); tick();
    chk("addr latch", addr, a);
  endtask

  task automatic rd_txn(input logic [31:0] a, input string tag);
    int  h0, k;
    hs_t h;
    set_addr(a);
    h0 = hs_tot;
    oe_n = 1'b0;
    k = 0;
    while (!isout && k < 40) begin tick(); k++; end
    chk({tag, " isout"}, isout, 1);
    chk({tag, " dout"}, dout, memf(a));
    oe_n = 1'b1;
    tick(); tick();
    chk({tag, " isout off"}, isout, 0);
    chk({tag, " hs count"}, hs_tot - h0, 1);
    if (hs_q.size() > 0) begin
      h = hs_q.pop_front();
      chk({tag, " hs addr"}, h.a, a);
      chk({tag, " hs rw"}, h.w, 0);
    end
  endtask

  task automatic wr_txn(input logic [31:0] a, input logic b, input logic [15:0] d,
                        input string tag);
    int  h0, k;
    logic [1:0] ws_m;
    hs_t h;
    ws_m = {~b, ~a[0]};
    set_addr(a);
    bhe_n = b;
    h0 = hs_tot;
    we_n = 1'b0; din = d; tick(); tick();
    we_n = 1'b1; din = 16'($urandom);
    k = 0;
    if (ws_m != 2'b00) while (hs_tot == h0 && k < 40) begin tick(); k++; end
    else repeat (12) tick();
    chk({tag, " hs count"}, hs_tot - h0, (ws_m != 2'b00) ? 1 : 0);
    if (ws_m != 2'b00 && hs_q.size() > 0) begin
      h = hs_q.pop_front();
      chk({tag, " hs addr"}, h.a, a);
      chk({tag, " hs rw"}, h.w, 1);
      chk({tag, " hs data"}, h.d, d);
      chk({tag, " hs wstrb"}, h.s, ws_m);
    end
    bhe_n = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v0, i0, h0, k;
    hs_t h;
    reset = 1'b1; din = '0; ale0 = 0; ale1 = 0; oe_n = 1; we_n = 1; bhe_n = 1;
    tick();
    do_reset();
    chk("rst dout", dout, 0);
    chk("rst isout", isout, 0);
    chk("rst valid", valid, 0);
    chk("rst rw", rw, 0);
    chk("rst addr", addr, 0);
    chk("rst mdout", mdout, 0);
    chk("rst wstrb", wstrb, 0);
    chk("rst err", err, 0);

    // Directed read with exact latency
    md_fix_en = 1'b1; md_fix = 16'hBEEF;
    set_addr(32'hABCD_1234);
    v0 = vcyc;
    oe_n = 1'b0;
    tick(); chk("rd stage isout", isout, 0); chk("rd stage valid", valid, 0);
    tick(); chk("rd valid", valid, 1); chk("rd addr", addr, 32'hABCD_1234); chk("rd rw", rw, 0);
    tick(); chk("rd isout", isout, 1); chk("rd dout", dout, 16'hBEEF); chk("rd valid drop", valid, 0);
    tick(); tick(); tick();
    oe_n = 1'b1;
    tick(); tick();
    chk("rd isout off", isout, 0);
    chk("rd valid cycles", vcyc - v0, 1);
    md_fix_en = 1'b0;

    // Byte writes
    hs_q.delete();
    wr_txn(32'h0000_0011, 1'b0, 16'h5A00, "bw hi");
    chk("bw wstrb", wstrb, 2'b10);
    wr_txn(32'h0000_0011, 1'b1, 16'h1357, "bw none");

    // Slow memory with OE withdrawn early
    ready_tie = 1'b0; dly = 9;
    set_addr(32'h0000_2468);
    v0 = vcyc; i0 = iscnt; h0 = hs_tot; stab_err = 0;
    oe_n = 1'b0;
    repeat (5) tick();
    oe_n = 1'b1;
    k = 0;
    while (hs_tot == h0 && k < 40) begin tick(); k++; end
    repeat (4) tick();
    chk("slow hs", hs_tot - h0, 1);
    chk("slow valid cycles", vcyc - v0, 10);
    chk("slow stable", stab_err, 0);
    chk("slow no isout", iscnt - i0, 0);
    if (hs_q.size() > 0) begin h = hs_q.pop_front(); chk("slow addr", h.a, 32'h0000_2468); end

    // Reset during a pending request
    dly = 20;
    set_addr(32'h0000_0042);
    oe_n = 1'b0;
    tick(); tick();
    chk("abort valid", valid, 1);
    reset = 1'b1; tick();
    chk("abort valid drop", valid, 0);
    reset = 1'b0; oe_n = 1'b1; tick(); tick();
    hs_q.delete();

    // OE and WE together
    ready_tie = 1'b1;
    set_addr(32'h0000_0100);
    v0 = vcyc; i0 = iscnt;
    oe_n = 1'b0; we_n = 1'b0;
    repeat (10) tick();
    oe_n = 1'b1; we_n = 1'b1;
    tick(); tick();
    chk("both err", err, 1);
    chk("both no valid", vcyc - v0, 0);
    chk("both no isout", iscnt - i0, 0);
    do_reset();
    chk("err cleared", err, 0);

    // Second OE edge during a slow read
    ready_tie = 1'b0; dly = 9;
    set_addr(32'h0000_0A0C);
    h0 = hs_tot;
    oe_n = 1'b0; repeat (4) tick();
    oe_n = 1'b1; tick(); tick();
    oe_n = 1'b0;
    k = 0;
    while (!isout && k < 40) begin tick(); k++; end
    chk("oe2 err", err, 1);
    chk("oe2 hs", hs_tot - h0, 1);
    chk("oe2 dout", dout, memf(32'h0000_0A0C));
    oe_n = 1'b1; tick(); tick();
    do_reset();

    // Decode on the windowed instance
    ready_tie = 1'b1;
    set_addr(32'h1000_0000);
    v0 = v2cnt; i0 = is2cnt;
    oe_n = 1'b0; repeat (8) tick(); oe_n = 1'b1; tick(); tick();
    chk("dec miss valid", v2cnt - v0, 0);
    chk("dec miss isout", is2cnt - i0, 0);
    set_addr(32'h8000_0004);
    v0 = v2cnt; i0 = is2cnt;
    oe_n = 1'b0; repeat (4) tick();
    chk("dec hit isout", isout2, 1);
    chk("dec hit dout", dout2, memf(32'h8000_0004));
    repeat (4) tick(); oe_n = 1'b1; tick(); tick();
    chk("dec hit valid", v2cnt - v0, 1);
    chk("dec hit isout off", isout2, 0);
    chk("dec err", err2, 0);
    do_reset();

    // Randomized traffic
    ready_tie = 1'b0;
    for (int t = 0; t < 24; t++) begin
      logic [31:0] a;
      a = $urandom;
      dly = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) rd_txn(a, "rand rd");
      else wr_txn(a, 1'($urandom_range(0, 1)), 16'($urandom), "rand wr");
    end
    chk("rand err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
